mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and data load/store (DM) of the single-issue core. Arbitrates, sequences a fixed-latency memory access with wait states, returns read data with a one-cycle done pulse, and raises stall to the core while any requester is still waiting. Sits between the core datapath/control and the memory macro.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (DM).
// Each access runs WAIT_CYCLES+1 cycles and is followed by a one-cycle done pulse.
// Optional conflict counter output is enabled by defining ARB_PERF_CNT_EN.

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_CYCLES);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic pick_if;
  logic last_cyc;

  // DM normally wins; IF is forced through once DM has won STARVE_MAX times in a row.
  assign pick_if  = if_req & (~dm_req | (starve_q == STARVE_LIM));
  assign last_cyc = (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (if_req || dm_req) begin
          state_d = S_ACCESS;
          if (pick_if) begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = OWN_DM;
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
              starve_d = starve_q + SCW'(1);
            end
          end
        end else begin
          starve_d = '0;
        end
      end
      S_ACCESS: begin
        if (last_cyc) begin
          state_d = S_DONE;
          wait_d  = '0;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt  = mem_en & (owner_q == OWN_IF) & (wait_q == '0);
  assign dm_gnt  = mem_en & (owner_q == OWN_DM) & (wait_q == '0);
  assign if_done = (state_q == S_DONE) & (owner_q == OWN_IF);
  assign dm_done = (state_q == S_DONE) & (owner_q == OWN_DM);

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q, conflict_d;
  logic        conflict_now;

  // A requester is blocked when it loses arbitration in IDLE or the other side owns the port.
  always_comb begin
    conflict_now = 1'b0;
    if (state_q == S_IDLE) begin
      conflict_now = if_req & dm_req;
    end else if (owner_q == OWN_IF) begin
      conflict_now = dm_req;
    end else begin
      conflict_now = if_req;
    end
    conflict_d = conflict_q;
    if (conflict_now && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses,
// a negedge monitor pops and compares whenever the DUT signals gnt/done.

module tb_mem_port_arbiter;

   localparam int WAIT    = 2;
   localparam int SMAX    = 4;
   localparam int TIMEOUT = 200;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic        ifGnt;
   logic        ifDone;
   logic [31:0] ifRdata;
   logic        dmReq;
   logic        dmWe;
   logic [31:0] dmAddr;
   logic [31:0] dmWdata;
   logic        dmGnt;
   logic        dmDone;
   logic [31:0] dmRdata;
   logic        memEn;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata = 32'h0;
   logic        stall;

   logic        w0IfReq;
   logic [31:0] w0IfAddr;
   logic        w0IfGnt;
   logic        w0IfDone;
   logic [31:0] w0IfRdata;
   logic        w0DmGnt;
   logic        w0DmDone;
   logic [31:0] w0DmRdata;
   logic        w0MemEn;
   logic        w0MemWe;
   logic [31:0] w0MemAddr;
   logic [31:0] w0MemWdata;
   logic [31:0] w0MemRdata;
   logic        w0Stall;
`ifdef ARB_PERF_CNT_EN
   logic [15:0] conflictCnt;
   logic [15:0] w0ConflictCnt;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   txn_t ifQ[$];
   txn_t dmQ[$];
   logic [31:0] lastDmRead = 32'h0;
   int   starve = 0;
   string grantStr = "";
   int   ifGntCyc = 0, ifDoneCyc = 0, dmGntCyc = 0, dmDoneCyc = 0;
   int   accCycle = 0;
   logic prevIfReq = 1'b0, prevDmReq = 1'b0;
   logic [31:0] curAddr = 32'h0, curWdata = 32'h0;
   logic        curWe = 1'b0;

   // Clock generation, 10 ns period
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT), .STARVE_MAX(SMAX)
   ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_done(ifDone), .if_rdata(ifRdata),
      .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
      .dm_gnt(dmGnt), .dm_done(dmDone), .dm_rdata(dmRdata),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .stall(stall)
`ifdef ARB_PERF_CNT_EN
      , .conflict_cnt(conflictCnt)
`endif
   );

   // Zero-wait-state instance exercising the shortest access sequence
   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_MAX(SMAX)
   ) u_dut0 (
      .clk(clk), .rst(rst),
      .if_req(w0IfReq), .if_addr(w0IfAddr), .if_gnt(w0IfGnt), .if_done(w0IfDone), .if_rdata(w0IfRdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_gnt(w0DmGnt), .dm_done(w0DmDone), .dm_rdata(w0DmRdata),
      .mem_en(w0MemEn), .mem_we(w0MemWe), .mem_addr(w0MemAddr), .mem_wdata(w0MemWdata),
      .mem_rdata(w0MemRdata), .stall(w0Stall)
`ifdef ARB_PERF_CNT_EN
      , .conflict_cnt(w0ConflictCnt)
`endif
   );

   // Memory contents: fixed word at 0x40, hashed pattern everywhere else
   function automatic logic [31:0] memData(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234_5678;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign w0MemRdata = w0MemEn ? memData(w0MemAddr) : 32'h0;

   // Single comparison point: counts every check and reports failures
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flagUnexpected(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: event seen with nothing expected", name);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issues one request, records its expected response, waits for done, then drops req
   task automatic applyStimulus(input bit isDm, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      txn_t t;
      int   n;
      bit   granted;
      bit   seen;
      t.addr  = addr;
      t.we    = isDm && we;
      t.wdata = wdata;
      if (isDm) begin
         t.rdata    = we ? lastDmRead : memData(addr);
         lastDmRead = t.rdata;
         dmQ.push_back(t);
         dmWe    = we;
         dmAddr  = addr;
         dmWdata = wdata;
         dmReq   = 1'b1;
      end else begin
         t.rdata = memData(addr);
         ifQ.push_back(t);
         ifAddr = addr;
         ifReq  = 1'b1;
      end
      n = 0;
      granted = 0;
      seen = 0;
      while (!seen && n < TIMEOUT) begin
         @(negedge clk);
         n++;
         seen = isDm ? dmDone : ifDone;
         if (granted && !seen) begin
            if (isDm) begin
               dmAddr  = $urandom;
               dmWdata = $urandom;
               dmWe    = 1'($urandom_range(0, 1));
            end else begin
               ifAddr = $urandom;
            end
         end
         if (isDm ? dmGnt : ifGnt) granted = 1;
      end
      checkOutput(isDm ? "dm_done_seen" : "if_done_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      if (isDm) dmReq = 1'b0;
      else ifReq = 1'b0;
   endtask

   // DM holds req high across n consecutive loads
   task automatic dmBurst(input int n);
      txn_t t;
      int   k;
      bit   seen;
      for (int i = 0; i < n; i++) begin
         t.addr  = 32'h100 + 32'(i * 4);
         t.we    = 1'b0;
         t.wdata = 32'h0;
         t.rdata = memData(t.addr);
         lastDmRead = t.rdata;
         dmQ.push_back(t);
         dmWe   = 1'b0;
         dmAddr = t.addr;
         dmReq  = 1'b1;
         k = 0;
         seen = 0;
         while (!seen && k < TIMEOUT) begin
            @(negedge clk);
            k++;
            seen = dmDone;
         end
         checkOutput("burst_done_seen", 32'(seen), 32'd1);
         @(posedge clk);
         #1;
      end
      dmReq = 1'b0;
   endtask

   // Monitor: pops the scoreboard on gnt/done and models arbitration and memory timing
   always @(negedge clk) begin
      bit expDm;
      txn_t t;
      if (rst) begin
         accCycle  = 0;
         prevIfReq = 1'b0;
         prevDmReq = 1'b0;
         starve    = 0;
      end else begin
         checkOutput("stall", 32'(stall), 32'((ifReq & ~ifDone) | (dmReq & ~dmDone)));
         if (ifGnt || dmGnt) begin
            expDm = prevDmReq && !(prevIfReq && starve == SMAX);
            checkOutput("arb_winner_dm", 32'(dmGnt), 32'(expDm));
            checkOutput("single_gnt", 32'(ifGnt & dmGnt), 32'd0);
         end
         if (ifGnt) begin
            if (ifQ.size() == 0) flagUnexpected("if_gnt");
            else begin
               curAddr = ifQ[0].addr; curWe = 1'b0; curWdata = 32'h0;
            end
            starve   = 0;
            grantStr = {grantStr, "I"};
            ifGntCyc = cyc;
         end
         if (dmGnt) begin
            if (dmQ.size() == 0) flagUnexpected("dm_gnt");
            else begin
               curAddr = dmQ[0].addr; curWe = dmQ[0].we; curWdata = dmQ[0].wdata;
            end
            starve   = prevIfReq ? ((starve < SMAX) ? starve + 1 : starve) : 0;
            grantStr = {grantStr, "D"};
            dmGntCyc = cyc;
         end
         if (memEn) begin
            accCycle++;
            checkOutput("mem_addr", memAddr, curAddr);
            checkOutput("mem_we", 32'(memWe), 32'(curWe));
            if (curWe) checkOutput("mem_wdata", memWdata, curWdata);
            if (accCycle > WAIT + 1) flagUnexpected("mem_en_too_long");
         end else if (accCycle != 0) begin
            checkOutput("access_len", 32'(accCycle), 32'(WAIT + 1));
            accCycle = 0;
         end
         checkOutput("gnt_first_cycle", 32'(ifGnt | dmGnt), 32'(memEn && accCycle == 1));
         if (ifDone) begin
            if (ifQ.size() == 0) flagUnexpected("if_done");
            else begin
               t = ifQ.pop_front();
               checkOutput("if_rdata", ifRdata, t.rdata);
               checkOutput("if_latency", 32'(cyc - ifGntCyc), 32'(WAIT + 1));
            end
            ifDoneCyc = cyc;
         end
         if (dmDone) begin
            if (dmQ.size() == 0) flagUnexpected("dm_done");
            else begin
               t = dmQ.pop_front();
               checkOutput("dm_rdata", dmRdata, t.rdata);
               checkOutput("dm_latency", 32'(cyc - dmGntCyc), 32'(WAIT + 1));
            end
            dmDoneCyc = cyc;
         end
         prevIfReq = ifReq;
         prevDmReq = dmReq;
      end
      memRdata = (memEn && accCycle == WAIT + 1) ? memData(memAddr) : (32'hBAD0_0000 ^ 32'(cyc));
   end

   // Global time bound so the run always ends
   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by a randomized phase
   initial begin
      int c0;
      int n;
      bit seen;
      txn_t t;
`ifdef ARB_PERF_CNT_EN
      logic [15:0] cntBefore;
`endif
      rst = 1'b1;
      ifReq = 1'b0; ifAddr = 32'h0;
      dmReq = 1'b0; dmWe = 1'b0; dmAddr = 32'h0; dmWdata = 32'h0;
      w0IfReq = 1'b0; w0IfAddr = 32'h0;
      idleCycles(3);

      $display("[TB] reset state");
      checkOutput("rst_mem_en", 32'(memEn), 32'd0);
      checkOutput("rst_mem_addr", memAddr, 32'h0);
      checkOutput("rst_if_rdata", ifRdata, 32'h0);
      checkOutput("rst_dm_rdata", dmRdata, 32'h0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      idleCycles(2);

      $display("[TB] IF-only read at 0x40");
      c0 = cyc;
      applyStimulus(0, 0, 32'h40, 32'h0);
      checkOutput("t1_gnt_cycle", 32'(ifGntCyc - c0), 32'd1);
      checkOutput("t1_done_cycle", 32'(ifDoneCyc - c0), 32'(WAIT + 2));
      checkOutput("t1_if_rdata", ifRdata, 32'h1234_5678);
      idleCycles(1);

      $display("[TB] simultaneous IF and DM load");
      grantStr = "";
`ifdef ARB_PERF_CNT_EN
      cntBefore = conflictCnt;
`endif
      c0 = cyc;
      fork
         applyStimulus(0, 0, 32'h200, 32'h0);
         applyStimulus(1, 0, 32'h100, 32'h0);
      join
      checkOutput("t2_dm_gnt", 32'(dmGntCyc - c0), 32'd1);
      checkOutput("t2_dm_done", 32'(dmDoneCyc - c0), 32'd4);
      checkOutput("t2_if_gnt", 32'(ifGntCyc - c0), 32'd6);
      checkOutput("t2_if_done", 32'(ifDoneCyc - c0), 32'd9);
`ifdef ARB_PERF_CNT_EN
      checkOutput("t2_conflicts", 32'(conflictCnt - cntBefore), 32'd5);
`endif
      idleCycles(1);

      $display("[TB] DM burst against pending IF");
      grantStr = "";
      fork
         applyStimulus(0, 0, 32'h400, 32'h0);
         dmBurst(5);
      join
      total++;
      if (grantStr != "DDDDID") begin
         bad++;
         $display("[TB] FAIL starve_order: got %s expected DDDDID", grantStr);
      end
      grantStr = "";
      fork
         applyStimulus(0, 0, 32'h404, 32'h0);
         applyStimulus(1, 0, 32'h108, 32'h0);
      join
      total++;
      if (grantStr != "DI") begin
         bad++;
         $display("[TB] FAIL starve_cleared: got %s expected DI", grantStr);
      end
      idleCycles(1);

      $display("[TB] DM store");
      applyStimulus(1, 1, 32'h80, 32'hDEAD_BEEF);
      checkOutput("t4_dm_rdata_kept", dmRdata, memData(32'h108));
      idleCycles(1);

      $display("[TB] reset during access");
      t.addr = 32'h300; t.we = 1'b0; t.wdata = 32'h0; t.rdata = memData(32'h300);
      dmQ.push_back(t);
      dmWe = 1'b0; dmAddr = 32'h300; dmReq = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < TIMEOUT) begin
         @(negedge clk);
         n++;
         seen = dmGnt;
      end
      checkOutput("t5_gnt_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_mem_en", 32'(memEn), 32'd0);
      checkOutput("t5_mem_we", 32'(memWe), 32'd0);
      checkOutput("t5_mem_addr", memAddr, 32'h0);
      checkOutput("t5_dm_done", 32'(dmDone), 32'd0);
      checkOutput("t5_dm_rdata", dmRdata, 32'h0);
      checkOutput("t5_if_rdata", ifRdata, 32'h0);
      dmReq = 1'b0;
      dmQ.delete();
      ifQ.delete();
      lastDmRead = 32'h0;
      idleCycles(2);
      rst = 1'b0;
      idleCycles(3);
      applyStimulus(1, 0, 32'h304, 32'h0);
      idleCycles(1);

      $display("[TB] randomized traffic");
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               idleCycles($urandom_range(0, 3));
               applyStimulus(0, 0, $urandom & 32'h0000_FFFC, 32'h0);
            end
         end
         begin
            for (int j = 0; j < 30; j++) begin
               idleCycles($urandom_range(0, 3));
               applyStimulus(1, 1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFC, $urandom);
            end
         end
      join
      idleCycles(2);
      checkOutput("if_queue_empty", 32'(ifQ.size()), 32'd0);
      checkOutput("dm_queue_empty", 32'(dmQ.size()), 32'd0);

      $display("[TB] zero wait states, back-to-back IF");
      w0IfAddr = 32'h40;
      w0IfReq = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         checkOutput("w0_gnt", 32'(w0IfGnt), 32'(k % 3 == 1));
         checkOutput("w0_done", 32'(w0IfDone), 32'(k > 0 && k % 3 == 2));
         if (k == 2) begin
            checkOutput("w0_rdata0", w0IfRdata, 32'h1234_5678);
            w0IfAddr = 32'h44;
         end
         if (k == 5) begin
            checkOutput("w0_rdata1", w0IfRdata, memData(32'h44));
            w0IfAddr = 32'h48;
         end
         if (k == 7) w0IfReq = 1'b0;
         if (k == 8) checkOutput("w0_rdata2", w0IfRdata, memData(32'h48));
      end
      idleCycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
